// File: rtl/dotn_ternary_accum.sv
// Ternary/binary dot product over VECTOR_LENGTH lanes with a registered adder tree
// and a saturating multi-chunk accumulator at the output.

module dotn_adder_tree #(
  parameter int N = 16,
  parameter int W = 17
) (
  input  logic                           clk,
  input  logic                           ena,
  input  logic [N*W-1:0]                 in_bus,
  output logic signed [W+$clog2(N)-1:0]  sum
);

  logic [(N/2)*(W+1)-1:0] lvl_d;
  logic [(N/2)*(W+1)-1:0] lvl_q;

  always_comb begin
    lvl_d = '0;
    for (int i = 0; i < N/2; i++) begin
      lvl_d[i*(W+1) +: W+1] = {in_bus[2*i*W + W-1], in_bus[2*i*W +: W]}
                            + {in_bus[(2*i+1)*W + W-1], in_bus[(2*i+1)*W +: W]};
    end
  end

  // one tree level per register
  always_ff @(posedge clk) begin
    if (ena) lvl_q <= lvl_d;
  end

  generate
    if (N == 2) begin : g_root
      assign sum = lvl_q;
    end else begin : g_next
      dotn_adder_tree #(.N(N/2), .W(W+1)) u_next (
        .clk    (clk),
        .ena    (ena),
        .in_bus (lvl_q),
        .sum    (sum)
      );
    end
  endgenerate

endmodule

module dotn_ternary_accum #(
  parameter int DATA_WIDTH    = 16,
  parameter int ACCU_WIDTH    = 32,
  parameter int VECTOR_LENGTH = 16,
  parameter int SAT_EN        = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  ena,
  input  logic                                  in_valid,
  input  logic                                  in_first,
  input  logic                                  in_last,
  input  logic                                  mode,
  input  logic signed [ACCU_WIDTH-1:0]          acc_init,
  input  logic [DATA_WIDTH*VECTOR_LENGTH-1:0]   a_in,
  input  logic [2*VECTOR_LENGTH-1:0]            b_code,
  output logic                                  out_valid,
  output logic signed [ACCU_WIDTH-1:0]          result,
  output logic                                  sat_flag
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ACCU_WIDTH;
  localparam int VL = VECTOR_LENGTH;
  localparam int LG = $clog2(VL);
  localparam int PW = DW + 1;
  localparam int SW = PW + LG;

  function automatic logic signed [PW-1:0] lane_prod(input logic signed [DW-1:0] a,
                                                     input logic [1:0] code,
                                                     input logic m);
    logic signed [PW-1:0] ax;
    ax = {a[DW-1], a};
    if (m) return code[0] ? ax : -ax;
    case (code)
      2'b01:   return ax;
      2'b10:   return -ax;
      default: return '0;
    endcase
  endfunction

  // Returns {step_sat, value}; value is clamped or wrapped depending on SAT_EN.
  function automatic logic [AW:0] acc_step(input logic signed [AW-1:0] base,
                                           input logic signed [SW-1:0] s);
    logic signed [AW:0] t;
    logic [AW:0]        r;
    t = {base[AW-1], base} + {{(AW+1-SW){s[SW-1]}}, s};
    if (t[AW] != t[AW-1]) begin
      if (SAT_EN != 0) r = {1'b1, (t[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}})};
      else             r = {1'b1, t[AW-1:0]};
    end else begin
      r = {1'b0, t[AW-1:0]};
    end
    return r;
  endfunction

  logic                  vld_p0_q, first_p0_q, last_p0_q, mode_p0_q;
  logic signed [AW-1:0]  init_p0_q;
  logic [DW*VL-1:0]      a_p0_q;
  logic [2*VL-1:0]       b_p0_q;

  logic                  vld_p1_q, first_p1_q, last_p1_q;
  logic signed [AW-1:0]  init_p1_q;
  logic [PW*VL-1:0]      prod_p1_d, prod_p1_q;

  logic [LG-1:0]         vld_t_q, first_t_q, last_t_q;
  logic signed [AW-1:0]  init_t_q [LG];
  logic signed [SW-1:0]  tree_sum;

  logic signed [AW-1:0]  acc_d, acc_q, result_d, result_q, base;
  logic                  sat_d, sat_q, sat_flag_d, sat_flag_q, out_valid_d, out_valid_q;
  logic [AW:0]           step;

  always_comb begin
    prod_p1_d = '0;
    for (int i = 0; i < VL; i++) begin
      prod_p1_d[i*PW +: PW] = lane_prod(a_p0_q[i*DW +: DW], b_p0_q[2*i +: 2], mode_p0_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_t_q  <= '0;
    end else if (ena) begin
      vld_p0_q   <= in_valid;
      vld_p1_q   <= vld_p0_q;
      vld_t_q[0] <= vld_p1_q;
      for (int k = 1; k < LG; k++) vld_t_q[k] <= vld_t_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (ena) begin
      // stage 1: input registers
      first_p0_q <= in_first;
      last_p0_q  <= in_last;
      mode_p0_q  <= mode;
      init_p0_q  <= acc_init;
      a_p0_q     <= a_in;
      b_p0_q     <= b_code;
      // stage 2: lane select
      first_p1_q <= first_p0_q;
      last_p1_q  <= last_p0_q;
      init_p1_q  <= init_p0_q;
      prod_p1_q  <= prod_p1_d;
      // tree stages: framing tags ride alongside the adder levels
      first_t_q[0] <= first_p1_q;
      last_t_q[0]  <= last_p1_q;
      init_t_q[0]  <= init_p1_q;
      for (int k = 1; k < LG; k++) begin
        first_t_q[k] <= first_t_q[k-1];
        last_t_q[k]  <= last_t_q[k-1];
        init_t_q[k]  <= init_t_q[k-1];
      end
    end
  end

  dotn_adder_tree #(.N(VL), .W(PW)) u_tree (
    .clk    (clk),
    .ena    (ena),
    .in_bus (prod_p1_q),
    .sum    (tree_sum)
  );

  // final stage: accumulate and publish
  always_comb begin
    acc_d       = acc_q;
    sat_d       = sat_q;
    result_d    = result_q;
    sat_flag_d  = sat_flag_q;
    out_valid_d = out_valid_q;
    base        = acc_q;
    step        = '0;
    if (ena) begin
      out_valid_d = 1'b0;
      if (vld_t_q[LG-1]) begin
        base  = first_t_q[LG-1] ? init_t_q[LG-1] : acc_q;
        step  = acc_step(base, tree_sum);
        acc_d = step[AW-1:0];
        sat_d = (first_t_q[LG-1] ? 1'b0 : sat_q) | step[AW];
        if (last_t_q[LG-1]) begin
          result_d    = step[AW-1:0];
          sat_flag_d  = sat_d;
          out_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      sat_q       <= 1'b0;
      result_q    <= '0;
      sat_flag_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      result_q    <= result_d;
      sat_flag_q  <= sat_flag_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_dotn_ternary_accum.sv
// Directed bench for dotn_ternary_accum at DATA_WIDTH=16, ACCU_WIDTH=32, VECTOR_LENGTH=16.

module tb_dotn_ternary_accum;

  localparam int DW = 16;
  localparam int AW = 32;
  localparam int VL = 16;

  logic          clk = 1'b0;
  logic          rst, ena, in_valid, in_first, in_last, mode;
  logic [AW-1:0] acc_init;
  logic [DW*VL-1:0] a_in;
  logic [2*VL-1:0]  b_code;
  logic          out_valid;
  logic [AW-1:0] result;
  logic          sat_flag;

  int total = 0;
  int bad   = 0;
  int lat;

  always #5 clk = ~clk;

  dotn_ternary_accum #(
    .DATA_WIDTH(DW), .ACCU_WIDTH(AW), .VECTOR_LENGTH(VL), .SAT_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .mode(mode), .acc_init(acc_init), .a_in(a_in),
    .b_code(b_code), .out_valid(out_valid), .result(result), .sat_flag(sat_flag)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a_all(input logic [DW-1:0] v);
    for (int i = 0; i < VL; i++) a_in[i*DW +: DW] = v;
  endtask

  task automatic set_b_all(input logic [1:0] c);
    for (int i = 0; i < VL; i++) b_code[2*i +: 2] = c;
  endtask

  // a_i = i+1, lanes 0-7 weight +1, lanes 8-15 weight -1
  task automatic set_ramp();
    for (int i = 0; i < VL; i++) begin
      a_in[i*DW +: DW]   = DW'(i + 1);
      b_code[2*i +: 2]   = (i < 8) ? 2'b01 : 2'b10;
    end
  endtask

  // Bubbles carry first/last=1 so that unqualified framing would corrupt results.
  task automatic send(input logic f, input logic l, input logic m, input logic [AW-1:0] init);
    in_valid = 1'b1; in_first = f; in_last = l; mode = m; acc_init = init;
    step();
    in_valid = 1'b0; in_first = 1'b1; in_last = 1'b1; mode = ~m;
  endtask

  task automatic wait_out(input int already, output int n_seen);
    n_seen = -1;
    for (int n = already + 1; n <= already + 40; n++) begin
      step();
      if (out_valid === 1'b1) begin
        n_seen = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    mode = 1'b0; acc_init = '0; a_in = '0; b_code = '0;
    step(); step(); step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result: got %0d want 0", $signed(result)); end
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL reset_sat_flag: got %b want 0", sat_flag); end
    rst = 1'b0;
    step(); step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_single();
    set_ramp();
    send(1'b1, 1'b1, 1'b0, 32'd100);
    wait_out(1, lat);
    total++; if (lat != 7) begin bad++; $display("FAIL single_latency: got %0d want 7", lat); end
    total++; if (result !== 32'd36) begin bad++; $display("FAIL single_result: got %0d want 36", $signed(result)); end
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL single_sat: got %b want 0", sat_flag); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_pulse_width: got %b want 0", out_valid); end
  endtask

  task automatic test_multi_chunk();
    set_a_all(16'd1000); set_b_all(2'b01);
    send(1'b1, 1'b0, 1'b0, 32'd5);
    send(1'b0, 1'b0, 1'b0, 32'd777);
    step();
    send(1'b0, 1'b1, 1'b0, 32'd777);
    wait_out(1, lat);
    total++; if (lat != 7) begin bad++; $display("FAIL multi_latency: got %0d want 7", lat); end
    total++; if (result !== 32'd48005) begin bad++; $display("FAIL multi_result: got %0d want 48005", $signed(result)); end
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL multi_sat: got %b want 0", sat_flag); end
  endtask

  task automatic test_neg_extreme();
    set_a_all(16'h8000); set_b_all(2'b10);
    send(1'b1, 1'b1, 1'b0, 32'd0);
    wait_out(1, lat);
    total++; if (result !== 32'd524288) begin bad++; $display("FAIL negmax_result: got %0d want 524288", $signed(result)); end
  endtask

  task automatic test_saturation();
    set_a_all(16'd100); set_b_all(2'b01);
    send(1'b1, 1'b1, 1'b0, 32'd2147482647);
    wait_out(1, lat);
    total++; if (result !== 32'h7FFFFFFF) begin bad++; $display("FAIL sat_pos_result: got %0d want 2147483647", $signed(result)); end
    total++; if (sat_flag !== 1'b1) begin bad++; $display("FAIL sat_pos_flag: got %b want 1", sat_flag); end
    set_a_all(16'd0);
    send(1'b1, 1'b1, 1'b0, 32'd0);
    wait_out(1, lat);
    total++; if (result !== 32'd0) begin bad++; $display("FAIL sat_clear_result: got %0d want 0", $signed(result)); end
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL sat_clear_flag: got %b want 0", sat_flag); end
    set_a_all(16'd100); set_b_all(2'b10);
    send(1'b1, 1'b1, 1'b0, 32'h8000000A);
    wait_out(1, lat);
    total++; if (result !== 32'h80000000) begin bad++; $display("FAIL sat_neg_result: got %0d want -2147483648", $signed(result)); end
    total++; if (sat_flag !== 1'b1) begin bad++; $display("FAIL sat_neg_flag: got %b want 1", sat_flag); end
    // clamps on chunk 0, then steps back into range: flag must stay sticky
    set_b_all(2'b01);
    send(1'b1, 1'b0, 1'b0, 32'd2147482647);
    set_b_all(2'b10);
    send(1'b0, 1'b1, 1'b0, 32'd0);
    wait_out(1, lat);
    total++; if (result !== 32'd2147482047) begin bad++; $display("FAIL sat_sticky_result: got %0d want 2147482047", $signed(result)); end
    total++; if (sat_flag !== 1'b1) begin bad++; $display("FAIL sat_sticky_flag: got %b want 1", sat_flag); end
  endtask

  task automatic test_binary_mode();
    set_a_all(16'd3); set_b_all(2'b00);
    send(1'b1, 1'b1, 1'b1, 32'd0);
    wait_out(1, lat);
    total++; if (result !== 32'hFFFFFFD0) begin bad++; $display("FAIL binary_00_result: got %0d want -48", $signed(result)); end
    send(1'b1, 1'b1, 1'b0, 32'd0);
    wait_out(1, lat);
    total++; if (result !== 32'd0) begin bad++; $display("FAIL ternary_00_result: got %0d want 0", $signed(result)); end
    set_b_all(2'b11);
    send(1'b1, 1'b1, 1'b1, 32'd0);
    wait_out(1, lat);
    total++; if (result !== 32'd48) begin bad++; $display("FAIL binary_11_result: got %0d want 48", $signed(result)); end
    send(1'b1, 1'b1, 1'b0, 32'd0);
    wait_out(1, lat);
    total++; if (result !== 32'd0) begin bad++; $display("FAIL ternary_11_result: got %0d want 0", $signed(result)); end
  endtask

  task automatic test_stall();
    logic early;
    early = 1'b0;
    set_ramp();
    send(1'b1, 1'b1, 1'b0, 32'd100);
    step(); step();
    ena = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (out_valid === 1'b1) early = 1'b1;
    end
    ena = 1'b1;
    total++; if (early !== 1'b0) begin bad++; $display("FAIL stall_early_valid: got %b want 0", early); end
    wait_out(7, lat);
    total++; if (lat != 11) begin bad++; $display("FAIL stall_latency: got %0d want 11", lat); end
    total++; if (result !== 32'd36) begin bad++; $display("FAIL stall_result: got %0d want 36", $signed(result)); end
    ena = 1'b0;
    step(); step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_stretch_valid: got %b want 1", out_valid); end
    total++; if (result !== 32'd36) begin bad++; $display("FAIL stall_stretch_result: got %0d want 36", $signed(result)); end
    ena = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_release_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    seen = 1'b0;
    set_a_all(16'd1000); set_b_all(2'b01);
    send(1'b1, 1'b0, 1'b0, 32'd5);
    for (int k = 0; k < 8; k++) step();
    send(1'b0, 1'b1, 1'b0, 32'd0);
    step();
    rst = 1'b1;
    #1;
    total++; if (result !== 32'd0) begin bad++; $display("FAIL rstmid_result: got %0d want 0", $signed(result)); end
    step();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_no_output: got %b want 0", seen); end
    set_a_all(16'd1);
    send(1'b0, 1'b1, 1'b0, 32'd999);
    wait_out(1, lat);
    total++; if (lat != 7) begin bad++; $display("FAIL rstmid_latency: got %0d want 7", lat); end
    total++; if (result !== 32'd16) begin bad++; $display("FAIL rstmid_result_after: got %0d want 16", $signed(result)); end
  endtask

  task automatic test_back_to_back();
    set_a_all(16'd1); set_b_all(2'b01);
    send(1'b1, 1'b0, 1'b0, 32'd1000);
    send(1'b1, 1'b1, 1'b0, 32'd1);
    set_a_all(16'd2); set_b_all(2'b10);
    send(1'b1, 1'b1, 1'b0, 32'd2);
    wait_out(3, lat);
    total++; if (lat != 8) begin bad++; $display("FAIL b2b_first_latency: got %0d want 8", lat); end
    total++; if (result !== 32'd17) begin bad++; $display("FAIL b2b_first_result: got %0d want 17", $signed(result)); end
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_second_valid: got %b want 1", out_valid); end
    total++; if (result !== 32'hFFFFFFE2) begin bad++; $display("FAIL b2b_second_result: got %0d want -30", $signed(result)); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_end_valid: got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_chunk();
    test_neg_extreme();
    test_saturation();
    test_binary_mode();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
